// File: rtl/mmio_seq_pkg.sv
// Shared types and constants for the MMIO host sequencer and the test ROMs that feed it.
package mmio_seq_pkg;

  localparam int unsigned RESP_DATA_W = 64;

  // Status registers commonly polled by self-test command streams.
  localparam logic [15:0] DONE_ADDR     = 16'h0060;
  localparam logic [15:0] RSA_DONE_ADDR = 16'h0074;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_RD   = 2'd1,
    OP_POLL = 2'd2,
    OP_NOP  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_GAP      = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   timeout;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

  function automatic logic poll_match(input logic [RESP_DATA_W-1:0] rd_val,
                                      input logic [RESP_DATA_W-1:0] cmp_val,
                                      input logic [RESP_DATA_W-1:0] mask);
    return ((rd_val ^ cmp_val) & mask) == {RESP_DATA_W{1'b0}};
  endfunction

endpackage

// File: rtl/mmio_host_sequencer.sv
// Command-driven MMIO initiator: one write, one read or a bounded polling read loop per command,
// followed by a single response pulse. All outputs come straight from flops.
module mmio_host_sequencer
  import mmio_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  mmio_wr_en,
  output logic [ADDR_WIDTH-1:0] mmio_wr_addr,
  output logic [DATA_WIDTH-1:0] mmio_wr_data,
  output logic                  mmio_rd_en,
  output logic [ADDR_WIDTH-1:0] mmio_rd_addr,
  input  logic [DATA_WIDTH-1:0] mmio_rd_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_timeout,
  output logic                  busy
);

  localparam int unsigned LAT_W    = $clog2(RD_LATENCY + 1);
  localparam int unsigned GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  state_t                   state_q, state_d;
  op_t                      op_q, op_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH-1:0]    mask_q, mask_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [TIMEOUT_WIDTH-1:0] reads_q, reads_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  resp_t                 resp_q, resp_d;

  logic accept_s;
  logic rd_done_s;
  logic match_s;
  logic reads_max_s;

  assign accept_s    = cmd_valid & cmd_ready_q;
  assign rd_done_s   = (state_q == S_RD_WAIT) && (lat_q == LAT_W'(RD_LATENCY));
  assign match_s     = poll_match(RESP_DATA_W'(mmio_rd_data), RESP_DATA_W'(data_q),
                                  RESP_DATA_W'(mask_q));
  assign reads_max_s = &reads_q;

  // State, latched command, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      lat_q       <= '0;
      gap_q       <= '0;
      reads_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      reads_q     <= reads_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      resp_q      <= resp_d;
    end
  end

  // Next-state and command/counter bookkeeping.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    reads_d = reads_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d    = op_t'(cmd_op);
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          mask_d  = cmd_mask;
          reads_d = '0;
          case (op_t'(cmd_op))
            OP_WR:   state_d = S_WR;
            OP_RD:   state_d = S_RD_ISSUE;
            OP_POLL: state_d = S_RD_ISSUE;
            OP_NOP:  state_d = S_RESP;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: state_d = S_RESP;
      S_RD_ISSUE: begin
        lat_d   = LAT_W'(1);
        reads_d = reads_max_s ? reads_q : reads_q + TIMEOUT_WIDTH'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_done_s) begin
          // Only a missed poll with reads left goes round again; everything else responds.
          if ((op_q == OP_POLL) && !match_s && !reads_max_s) begin
            gap_d   = '0;
            state_d = (POLL_GAP == 0) ? S_RD_ISSUE : S_GAP;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = S_RD_ISSUE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wr_en_d     = (state_d == S_WR);
    wr_addr_d   = wr_en_d ? addr_d : wr_addr_q;
    wr_data_d   = wr_en_d ? data_d : wr_data_q;
    rd_en_d     = (state_d == S_RD_ISSUE);
    rd_addr_d   = rd_en_d ? addr_d : rd_addr_q;
    resp_d      = '0;
    if (state_d == S_RESP) begin
      resp_d.valid   = 1'b1;
      resp_d.timeout = rd_done_s & (op_q == OP_POLL) & ~match_s;
      resp_d.data    = rd_done_s ? RESP_DATA_W'(mmio_rd_data) : {RESP_DATA_W{1'b0}};
    end else begin
      resp_d = '0;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign mmio_wr_en   = wr_en_q;
  assign mmio_wr_addr = wr_addr_q;
  assign mmio_wr_data = wr_data_q;
  assign mmio_rd_en   = rd_en_q;
  assign mmio_rd_addr = rd_addr_q;
  assign resp_valid   = resp_q.valid;
  assign resp_timeout = resp_q.timeout;
  assign resp_data    = resp_q.data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mmio_host_sequencer.sv
// Directed plus randomized bench for mmio_host_sequencer against a behavioural register-file slave.
module tb_mmio_host_sequencer;
  import mmio_seq_pkg::*;

  localparam int LAT   = 1;
  localparam int GAP   = 4;
  localparam int TW    = 4;
  localparam int SPACE = 1 + LAT + GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = 16'd0;
  logic [63:0] cmd_data = 64'd0;
  logic [63:0] cmd_mask = 64'd0;
  logic        mmio_wr_en, mmio_rd_en;
  logic [15:0] mmio_wr_addr, mmio_rd_addr;
  logic [63:0] mmio_wr_data, mmio_rd_data;
  logic        resp_valid, resp_timeout, busy;
  logic [63:0] resp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_host_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .RD_LATENCY(LAT), .POLL_GAP(GAP), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_data(mmio_rd_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy)
  );

  // Slave: register file with 1-cycle read latency; DONE_ADDR reads 1 once cyc reaches done_at.
  int          cyc = 0;
  int          done_at = 32'h7fff_ffff;
  logic [63:0] mem [0:255] = '{default: 64'd0};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mmio_wr_en) mem[mmio_wr_addr[7:0]] <= mmio_wr_data;
    if (mmio_rd_en) begin
      if (mmio_rd_addr == DONE_ADDR) mmio_rd_data <= (cyc >= done_at) ? 64'd1 : 64'd0;
      else                           mmio_rd_data <= mem[mmio_rd_addr[7:0]];
    end
  end

  // Monitor: logs strobes and responses with their cycle index.
  logic        mon_en = 1'b0;
  int          wr_cnt = 0, rd_n = 0, rsp_n = 0, ovl_cnt = 0, rdy_bad = 0, last_wr_cyc = 0;
  logic [15:0] last_wr_addr = 16'd0;
  logic [63:0] last_wr_data = 64'd0;
  int          rd_cyc [0:511];
  int          rsp_cyc [0:127];
  logic [63:0] rsp_dat [0:127];
  logic        rsp_to  [0:127];
  always @(negedge clk) begin
    if (mon_en) begin
      if (mmio_wr_en) begin
        wr_cnt <= wr_cnt + 1; last_wr_cyc <= cyc;
        last_wr_addr <= mmio_wr_addr; last_wr_data <= mmio_wr_data;
      end
      if (mmio_rd_en && rd_n < 512) begin rd_cyc[rd_n] <= cyc; rd_n <= rd_n + 1; end
      if (resp_valid && rsp_n < 128) begin
        rsp_cyc[rsp_n] <= cyc; rsp_dat[rsp_n] <= resp_data; rsp_to[rsp_n] <= resp_timeout;
        rsp_n <= rsp_n + 1;
      end
      if (mmio_wr_en && mmio_rd_en) ovl_cnt <= ovl_cnt + 1;
      if (cmd_ready === busy) rdy_bad <= rdy_bad + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for exactly one accepting edge; acc is the accept cycle index.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [63:0] d,
                      input logic [63:0] m, output int acc);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
    cmd_data = {$urandom, $urandom}; cmd_mask = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_n < n && k < 400) begin @(negedge clk); #1; k++; end
    chk(tag, 64'(rsp_n), 64'(n));
  endtask

  initial begin
    logic [63:0] ref_mem [0:255];
    op_t         ops5 [3];
    int acc, rb, wb, base, k, nexp, n;
    logic [15:0] a;
    logic [63:0] d, m, exp_d;
    logic [1:0]  op;
    for (int i = 0; i < 256; i++) ref_mem[i] = 64'd0;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(mmio_wr_en), 64'd0);
    chk("rst_rd_en", 64'(mmio_rd_en), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: write
    wb = wr_cnt; base = rsp_n;
    send(OP_WR, 16'h0052, 64'hDEAD_BEEF, 64'd0, acc);
    ref_mem[8'h52] = 64'hDEAD_BEEF;
    wait_rsp(base + 1, "wr_resp_seen");
    chk("wr_pulses", 64'(wr_cnt - wb), 64'd1);
    chk("wr_cycle", 64'(last_wr_cyc - acc), 64'd1);
    chk("wr_addr", 64'(last_wr_addr), 64'h0052);
    chk("wr_data", last_wr_data, 64'hDEAD_BEEF);
    chk("wr_resp_cycle", 64'(rsp_cyc[base] - acc), 64'd2);
    chk("wr_resp_data", rsp_dat[base], 64'd0);

    // 2: read back
    rb = rd_n; base = rsp_n;
    send(OP_RD, 16'h0052, 64'd0, 64'd0, acc);
    wait_rsp(base + 1, "rd_resp_seen");
    chk("rd_pulses", 64'(rd_n - rb), 64'd1);
    chk("rd_resp_cycle", 64'(rsp_cyc[base] - acc), 64'd3);
    chk("rd_resp_data", rsp_dat[base], 64'hDEAD_BEEF);
    chk("rd_resp_timeout", 64'(rsp_to[base]), 64'd0);

    // 3: poll done, set 20 cycles after accept
    rb = rd_n; base = rsp_n;
    send(OP_POLL, DONE_ADDR, 64'd1, 64'd1, acc);
    done_at = acc + 20;
    k = 0;
    while (acc + 1 + SPACE * k < done_at) k++;
    nexp = k + 1;
    wait_rsp(base + 1, "poll_resp_seen");
    chk("poll_reads", 64'(rd_n - rb), 64'(nexp));
    for (int i = 1; i < nexp && rb + i < rd_n; i++)
      chk("poll_spacing", 64'(rd_cyc[rb + i] - rd_cyc[rb + i - 1]), 64'(SPACE));
    chk("poll_timeout", 64'(rsp_to[base]), 64'd0);
    chk("poll_data0", 64'(rsp_dat[base][0]), 64'd1);
    chk("poll_resp_cycle", 64'(rsp_cyc[base] - acc), 64'(1 + SPACE * (nexp - 1) + 1 + LAT));

    // 4: poll never satisfied
    done_at = 32'h7fff_ffff;
    rb = rd_n; base = rsp_n;
    send(OP_POLL, DONE_ADDR, 64'd1, 64'd1, acc);
    wait_rsp(base + 1, "tmo_resp_seen");
    chk("tmo_reads", 64'(rd_n - rb), 64'((1 << TW) - 1));
    chk("tmo_timeout", 64'(rsp_to[base]), 64'd1);
    chk("tmo_data", rsp_dat[base], 64'd0);
    chk("tmo_resp_cycle", 64'(rsp_cyc[base] - acc), 64'(1 + SPACE * ((1 << TW) - 2) + 1 + LAT));

    // 5: back-to-back WR, RD, NOP with cmd_valid held
    base = rsp_n;
    a = 16'($urandom_range(0, 63)); d = {$urandom, $urandom};
    ops5 = '{OP_WR, OP_RD, OP_NOP};
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("b2b_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = ops5[i]; cmd_addr = a; cmd_data = d; cmd_mask = 64'd0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    ref_mem[a[7:0]] = d;
    wait_rsp(base + 3, "b2b_resp_seen");
    chk("b2b_wr_data", rsp_dat[base], 64'd0);
    chk("b2b_rd_data", rsp_dat[base + 1], d);
    chk("b2b_nop_data", rsp_dat[base + 2], 64'd0);
    chk("b2b_order", 64'((rsp_cyc[base] < rsp_cyc[base + 1]) && (rsp_cyc[base + 1] < rsp_cyc[base + 2])), 64'd1);

    // 6: reset during RD_WAIT
    base = rsp_n;
    send(OP_RD, 16'h0052, 64'd0, 64'd0, acc);
    @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_rd_en", 64'(mmio_rd_en), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_resp", 64'(rsp_n), 64'(base));
    d = {$urandom, $urandom};
    send(OP_WR, 16'h0070, d, 64'd0, acc);
    ref_mem[8'h70] = d;
    send(OP_RD, 16'h0070, 64'd0, 64'd0, acc);
    wait_rsp(base + 2, "post_rst_resp_seen");
    chk("post_rst_rd_data", rsp_dat[base + 1], d);

    // Randomized commands against the reference register file
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom_range(0, 63));
      d  = {$urandom, $urandom};
      m  = 64'd0;
      if (op == 2'(OP_POLL) && $urandom_range(0, 1) == 1) begin
        m = 64'hFFFF_FFFF_FFFF_FFFF; d = ref_mem[a[7:0]];
      end
      base = rsp_n;
      send(op, a, d, m, acc);
      exp_d = (op == 2'(OP_RD) || op == 2'(OP_POLL)) ? ref_mem[a[7:0]] : 64'd0;
      if (op == 2'(OP_WR)) ref_mem[a[7:0]] = d;
      wait_rsp(base + 1, "rnd_resp_seen");
      chk("rnd_data", rsp_dat[base], exp_d);
      chk("rnd_timeout", 64'(rsp_to[base]), 64'd0);
      chk("rnd_latency", 64'(rsp_cyc[base] - acc),
          (op == 2'(OP_WR)) ? 64'd2 : (op == 2'(OP_NOP)) ? 64'd1 : 64'(2 + LAT));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("strobe_overlap", 64'(ovl_cnt), 64'd0);
    chk("ready_vs_busy", 64'(rdy_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
